// File: rtl/credit_ledger.sv
// Credit and payout sequencer for the slot machine: keeps the credit balance and last win,
// charges bets, pays wins back one credit per tick, and presents everything as BCD digits.
module credit_ledger #(
  parameter int BET         = 1,
  parameter int INIT_CREDIT = 0,
  parameter int TICK_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin_pulse,
  input  logic       spin_req,
  input  logic       win_valid,
  input  logic [6:0] win_amt,
  output logic       spin_start,
  output logic       insufficient,
  output logic       busy,
  output logic       payout_active,
  output logic [3:0] won_amt1,
  output logic [3:0] won_amt2,
  output logic [3:0] credit_amt1,
  output logic [3:0] credit_amt2,
  output logic [3:0] credit_amt3
);

  localparam int            CW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_CYCLES - 1);
  localparam logic [9:0]    BET_W      = 10'(BET);
  localparam logic [9:0]    INIT_W     = 10'(INIT_CREDIT);
  localparam logic [9:0]    CREDIT_MAX = 10'd999;

  typedef enum logic [1:0] {IDLE, SPIN, PAYOUT} state_t;

  state_t        state_reg, state_next;
  logic [9:0]    credit_reg, credit_next;
  logic [6:0]    won_reg, won_next;
  logic [6:0]    remaining_reg, remaining_next;
  logic [CW-1:0] tick_reg, tick_next;
  logic          spin_start_next, insufficient_next;
  logic [6:0]    win_clamped;
  logic          accept, tick_done;
  logic [10:0]   credit_sum;

  function automatic logic [11:0] to_bcd3(input logic [9:0] v);
    int n;
    n = int'(v);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    int n;
    n = int'(v);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  always_comb begin
    state_next        = state_reg;
    won_next          = won_reg;
    remaining_next    = remaining_reg;
    tick_next         = tick_reg;
    spin_start_next   = 1'b0;
    insufficient_next = 1'b0;
    accept            = 1'b0;
    tick_done         = 1'b0;
    win_clamped       = (win_amt > 7'd99) ? 7'd99 : win_amt;

    case (state_reg)
      IDLE: begin
        if (spin_req) begin
          // Affordability is judged on the balance before any coin arriving this cycle.
          if (credit_reg >= BET_W) begin
            accept          = 1'b1;
            spin_start_next = 1'b1;
            won_next        = '0;
            state_next      = SPIN;
          end else begin
            insufficient_next = 1'b1;
          end
        end
      end
      SPIN: begin
        if (win_valid) begin
          won_next       = win_clamped;
          remaining_next = win_clamped;
          tick_next      = '0;
          state_next     = (win_clamped == 7'd0) ? IDLE : PAYOUT;
        end
      end
      PAYOUT: begin
        if (tick_reg == TICK_LAST) begin
          tick_done      = 1'b1;
          tick_next      = '0;
          remaining_next = remaining_reg - 7'd1;
          if (remaining_reg == 7'd1) state_next = IDLE;
        end else begin
          tick_next = tick_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A coin and a payout tick may land together; both saturate at the display limit.
    credit_sum = {1'b0, credit_reg} + {10'd0, coin_pulse} + {10'd0, tick_done};
    if (accept)
      credit_next = credit_reg - BET_W + {9'd0, coin_pulse};
    else if (credit_sum > {1'b0, CREDIT_MAX})
      credit_next = CREDIT_MAX;
    else
      credit_next = credit_sum[9:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      credit_reg    <= INIT_W;
      won_reg       <= '0;
      remaining_reg <= '0;
      tick_reg      <= '0;
      spin_start    <= 1'b0;
      insufficient  <= 1'b0;
      busy          <= 1'b0;
      payout_active <= 1'b0;
      {credit_amt1, credit_amt2, credit_amt3} <= to_bcd3(INIT_W);
      {won_amt1, won_amt2}                    <= 8'h00;
    end else begin
      state_reg     <= state_next;
      credit_reg    <= credit_next;
      won_reg       <= won_next;
      remaining_reg <= remaining_next;
      tick_reg      <= tick_next;
      spin_start    <= spin_start_next;
      insufficient  <= insufficient_next;
      busy          <= (state_next != IDLE);
      payout_active <= (state_next == PAYOUT);
      {credit_amt1, credit_amt2, credit_amt3} <= to_bcd3(credit_next);
      {won_amt1, won_amt2}                    <= to_bcd2(won_next);
    end
  end

endmodule

// File: tb/tb_credit_ledger.sv
// Scoreboard bench for credit_ledger: stimulus queues the expected output word and the cycle it
// must appear in; a monitor pops one entry every time the sampled outputs change.
module tb_credit_ledger;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       coin_pulse, spin_req, win_valid;
  logic [6:0] win_amt;
  logic       spin_start, insufficient, busy, payout_active;
  logic [3:0] won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3;

  typedef struct packed {
    logic [3:0] c1, c2, c3, w1, w2;
    logic       ss, ins, bz, pa;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    cyc;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  credit_ledger #(.BET(1), .INIT_CREDIT(0), .TICK_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .coin_pulse(coin_pulse), .spin_req(spin_req),
    .win_valid(win_valid), .win_amt(win_amt), .spin_start(spin_start),
    .insufficient(insufficient), .busy(busy), .payout_active(payout_active),
    .won_amt1(won_amt1), .won_amt2(won_amt2), .credit_amt1(credit_amt1),
    .credit_amt2(credit_amt2), .credit_amt3(credit_amt3)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(int cr, int wn, bit ss, bit ins, bit bz, bit pa);
    obs_t o;
    o.c1 = 4'(cr / 100); o.c2 = 4'((cr / 10) % 10); o.c3 = 4'(cr % 10);
    o.w1 = 4'(wn / 10);  o.w2 = 4'(wn % 10);
    o.ss = ss; o.ins = ins; o.bz = bz; o.pa = pa;
    return o;
  endfunction

  task automatic expect_at(string name, obs_t o, int c);
    exp_t e;
    e.o = o; e.cyc = c; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic coin(int cr, int wn, bit changes);
    if (changes) expect_at("coin", mk(cr, wn, 0, 0, 0, 0), cyc + 1);
    coin_pulse = 1'b1; step(); coin_pulse = 1'b0; step();
  endtask

  // Accepted spin: credit shown after the bet, won cleared, one-cycle spin_start.
  task automatic spin(int cr);
    expect_at("spin_start", mk(cr, 0, 1, 0, 1, 0), cyc + 1);
    expect_at("spin_busy",  mk(cr, 0, 0, 0, 1, 0), cyc + 2);
    spin_req = 1'b1; step(); spin_req = 1'b0; step();
  endtask

  task automatic win_zero(int cr);
    expect_at("win_zero", mk(cr, 0, 0, 0, 0, 0), cyc + 1);
    win_valid = 1'b1; win_amt = 7'd0; step(); win_valid = 1'b0;
  endtask

  // Monitor: every change of the observed output word consumes one expectation.
  initial begin
    obs_t cur, prev;
    exp_t e;
    prev = '1;
    forever begin
      @(negedge clk);
      cur = {credit_amt1, credit_amt2, credit_amt3, won_amt1, won_amt2,
             spin_start, insufficient, busy, payout_active};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h at cyc %0d, required no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.o || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL %s: got %h at cyc %0d, required %h at cyc %0d",
                     e.name, cur, cyc, e.o, e.cyc);
          end else begin
            $display("ok %s: %h at cyc %0d", e.name, cur, cyc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #400000;
    if (!done) begin
      $display("FAIL watchdog: got no end of stimulus, required completion within 400000 ns");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    int m;
    coin_pulse = 1'b0; spin_req = 1'b0; win_valid = 1'b0; win_amt = 7'd0; reset_n = 1'b1;
    expect_at("reset", mk(0, 0, 0, 0, 0, 0), -1);
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    step();

    // Three coins then a spin; zero wins return straight to IDLE.
    for (int c = 1; c <= 3; c++) coin(c, 0, 1);
    spin(2); win_zero(2);
    spin(1); win_zero(1);
    spin(0); win_zero(0);

    // Refused spin at zero credit, then coin and spin together (refused, credit becomes 1).
    expect_at("refuse",     mk(0, 0, 0, 1, 0, 0), cyc + 1);
    expect_at("refuse_end", mk(0, 0, 0, 0, 0, 0), cyc + 2);
    spin_req = 1'b1; step(); spin_req = 1'b0; step();
    expect_at("coin_spin",     mk(1, 0, 0, 1, 0, 0), cyc + 1);
    expect_at("coin_spin_end", mk(1, 0, 0, 0, 0, 0), cyc + 2);
    coin_pulse = 1'b1; spin_req = 1'b1; step(); coin_pulse = 1'b0; spin_req = 1'b0; step();
    coin(2, 0, 1);

    // Win of 12 from credit 2: one increment every 4 cycles; spin_req in SPIN ignored.
    spin(1);
    spin_req = 1'b1; step(); spin_req = 1'b0; step();
    m = cyc;
    expect_at("pay12_enter", mk(1, 12, 0, 0, 1, 1), m + 1);
    for (int j = 1; j <= 11; j++) expect_at("pay12_tick", mk(1 + j, 12, 0, 0, 1, 1), m + 1 + 4 * j);
    expect_at("pay12_done", mk(13, 12, 0, 0, 0, 0), m + 49);
    win_valid = 1'b1; win_amt = 7'd12; step(); win_valid = 1'b0;
    repeat (52) step();

    // Win of 5 with a coin on the second tick; win_valid and spin_req during PAYOUT ignored.
    spin(12);
    m = cyc;
    expect_at("pay5_enter",  mk(12, 5, 0, 0, 1, 1), m + 1);
    expect_at("pay5_tick1",  mk(13, 5, 0, 0, 1, 1), m + 5);
    expect_at("pay5_coin",   mk(15, 5, 0, 0, 1, 1), m + 9);
    expect_at("pay5_tick3",  mk(16, 5, 0, 0, 1, 1), m + 13);
    expect_at("pay5_tick4",  mk(17, 5, 0, 0, 1, 1), m + 17);
    expect_at("pay5_done",   mk(18, 5, 0, 0, 0, 0), m + 21);
    win_valid = 1'b1; win_amt = 7'd5; step(); win_valid = 1'b0;
    repeat (7) step();
    coin_pulse = 1'b1; step(); coin_pulse = 1'b0;
    repeat (3) step();
    win_valid = 1'b1; win_amt = 7'd50; step(); win_valid = 1'b0;
    step();
    spin_req = 1'b1; step(); spin_req = 1'b0;
    repeat (10) step();

    // Fill to 999, one saturated coin, then a clamped win of 120 that drains for 99 ticks.
    for (int c = 19; c <= 999; c++) coin(c, 5, 1);
    coin(999, 5, 0);
    spin(998);
    m = cyc;
    expect_at("pay99_enter", mk(998, 99, 0, 0, 1, 1), m + 1);
    expect_at("pay99_sat",   mk(999, 99, 0, 0, 1, 1), m + 5);
    expect_at("pay99_done",  mk(999, 99, 0, 0, 0, 0), m + 397);
    win_valid = 1'b1; win_amt = 7'd120; step(); win_valid = 1'b0;
    repeat (400) step();

    // Asynchronous reset mid-payout, off the clock edge: outputs clear in the same cycle.
    spin(998);
    m = cyc;
    expect_at("pay7_enter", mk(998, 7, 0, 0, 1, 1), m + 1);
    expect_at("pay7_tick",  mk(999, 7, 0, 0, 1, 1), m + 5);
    win_valid = 1'b1; win_amt = 7'd7; step(); win_valid = 1'b0;
    repeat (6) step();
    expect_at("async_reset", mk(0, 0, 0, 0, 0, 0), cyc);
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    repeat (12) step();
    coin(1, 0, 1);
    repeat (4) step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations (next %s), required 0",
               exp_q.size(), exp_q[0].name);
    end
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_ledger.md
Name: credit_ledger

Overview:
Credit and payout sequencer for the slot machine.
- Keeps the player's credit balance (0–999) and the last win amount (0–99).
- Accepts coin inserts, charges the bet when a spin is requested, and pays wins back into credit one unit per animation tick.
- Drives the five BCD digit inputs of the multiplexed seven-segment display controller: two won digits, three credit digits.

Parameters:
- BET, default 1: credits charged per spin; legal range 1–9.
- INIT_CREDIT, default 0: credit balance after reset; legal range 0–999.
- TICK_CYCLES, default 5000000: clk cycles per payout increment; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- coin_pulse  in  1  single-cycle pulse, adds one credit; already synchronized and debounced.
- spin_req  in  1  single-cycle pulse, player requests a spin.
- win_valid  in  1  single-cycle pulse, spin result is available on win_amt.
- win_amt  in  7  binary win amount; values above 99 are clamped to 99.
- spin_start  out  1  registered single-cycle pulse, tells the reel logic to start spinning.
- insufficient  out  1  registered single-cycle pulse, spin refused because credit < BET.
- busy  out  1  high whenever the state is not IDLE.
- payout_active  out  1  high in PAYOUT.
- won_amt1  out  4  won amount, tens digit (BCD).
- won_amt2  out  4  won amount, ones digit (BCD).
- credit_amt1  out  4  credit, hundreds digit (BCD).
- credit_amt2  out  4  credit, tens digit (BCD).
- credit_amt3  out  4  credit, ones digit (BCD).

Behaviour:
Reset (asynchronous, while reset_n is low):
- Credit = INIT_CREDIT; won = 0; remaining = 0; tick counter = 0; state = IDLE.
- All pulse outputs are 0.
- Reset asserted mid-spin or mid-payout aborts the operation; any undelivered payout is lost.

General rules:
- All outputs are registered. An event sampled at edge N is visible after edge N. BCD digits are always valid (0–9).
- Credit arithmetic saturates at 999. It can never underflow, because a bet is only taken when credit >= BET.

IDLE:
- spin_req with credit >= BET:
  - credit -= BET, won cleared to 0.
  - spin_start pulses for one cycle.
  - Next state is SPIN.
- spin_req with credit < BET: insufficient pulses for one cycle; state stays IDLE; credit unchanged.

SPIN:
- Waits for win_valid. Then won = min(win_amt, 99) and remaining = won.
- If won == 0, go to IDLE. Otherwise go to PAYOUT with the tick counter cleared.

PAYOUT:
- The tick counter runs 0 .. TICK_CYCLES-1.
- At its terminal count: credit += 1 (saturating), remaining -= 1, counter wraps to 0.
- When remaining reaches 0, go to IDLE in the same cycle as the last increment.
- If credit is saturated at 999, payout still drains at the tick rate; excess is discarded.
- The won digits keep showing the full won amount until the next accepted spin.

Ignored inputs:
- spin_req outside IDLE has no effect; it produces no insufficient pulse and is not queued.
- win_valid outside SPIN has no effect.

coin_pulse:
- Accepted in every state, adds 1 to credit (saturating).
- Coin plus payout tick in the same cycle: credit += 2, saturating.
- Coin plus accepted spin in the same cycle: credit += 1 - BET. The acceptance check uses the pre-coin credit.
  - Example: credit 0, BET 1, coin and spin together: spin refused, credit becomes 1.

Test Plan:
1. Reset with INIT_CREDIT=0. Apply three coin_pulse, then spin_req (BET=1). Required: credit 000→003→002, spin_start exactly one cycle, busy=1, won digits 0,0.
2. Credit 0, spin_req. Required: insufficient for one cycle, spin_start never asserted, state IDLE, credit 000.
3. TICK_CYCLES=4, credit 002, spin, then win_valid with win_amt=12. Required: won digits 1,2; credit steps 001→013 with one increment every 4 cycles; payout_active falls after the 12th increment; won still shows 12.
4. TICK_CYCLES=4, credit 998, win_amt=120. Required: won shows 99, credit saturates at 999, payout lasts 99 ticks, then IDLE.
5. In PAYOUT, coin_pulse coincident with a tick. Required: credit +2 that cycle. A win_valid and a spin_req during PAYOUT are both ignored.
6. Mid-PAYOUT, assert reset_n low asynchronously (not aligned to clk). Required: outputs return to INIT_CREDIT and won 0 immediately, busy=0, no spin_start afterwards.
